// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction fetch
// path and the data load/store path. One access at a time, data first,
// with a bounded data streak so a pending fetch cannot starve.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_rdy
);

    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] streak;
    logic          is_write;
    logic          dgrant_c;
    logic          igrant_c;
    logic          write_nxt;
    logic          ren_nxt;
    logic          wen_nxt;
    logic          ihit_nxt;
    logic          dhit_nxt;

    // Arbitration in IDLE: data wins unless a fetch is waiting on a full streak
    always_comb begin
        dgrant_c = 1'b0;
        igrant_c = 1'b0;
        if (state == IDLE) begin
            dgrant_c = (dREN | dWEN) && !(iREN && (streak == STREAK_MAX));
            igrant_c = iREN && !dgrant_c;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dgrant_c) begin
                    next_state = DACC;
                end else if (igrant_c) begin
                    next_state = IACC;
                end
            end
            IACC, DACC: begin
                if (ram_rdy) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: next-cycle values for the registered RAM enables and hits
    always_comb begin
        ren_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        ihit_nxt  = 1'b0;
        dhit_nxt  = 1'b0;
        write_nxt = (state == IDLE) ? dWEN : is_write;
        case (next_state)
            IACC:    ren_nxt = 1'b1;
            DACC: begin
                wen_nxt = write_nxt;
                ren_nxt = !write_nxt;
            end
            default: begin
                ren_nxt = 1'b0;
                wen_nxt = 1'b0;
            end
        endcase
        if (ram_rdy && (state == IACC)) begin
            ihit_nxt = 1'b1;
        end
        if (ram_rdy && (state == DACC)) begin
            dhit_nxt = 1'b1;
        end
    end

    // Request latch, RAM port registers, load capture and hit pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            is_write  <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            ram_ren <= ren_nxt;
            ram_wen <= wen_nxt;
            ihit    <= ihit_nxt;
            dhit    <= dhit_nxt;
            if (dgrant_c) begin
                ram_addr  <= daddr;
                ram_store <= dstore;
                is_write  <= dWEN;
            end else if (igrant_c) begin
                ram_addr <= iaddr;
            end
            if (ihit_nxt) begin
                iload <= ram_load;
            end
            if (dhit_nxt && !is_write) begin
                dload <= ram_load;
            end
        end
    end

    // Data streak counter: counts data grants made over a waiting fetch
    always_ff @(posedge CLK) begin
        if (RST) begin
            streak <= '0;
        end else if (dgrant_c) begin
            if (!iREN) begin
                streak <= '0;
            end else if (streak < STREAK_MAX) begin
                streak <= streak + SW'(1);
            end
        end else if (igrant_c) begin
            streak <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven single accesses against a RAM
// model, reset corner cases and the data/fetch fairness sequence.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_rdy;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_rdy(ram_rdy)
    );

    // kind: 0 fetch, 1 data read, 2 data write, 3 read+write (write wins)
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        int          waits;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_iload = '0;
    logic [31:0] m_dload = '0;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_rdy = 1'b0;
    endtask

    // One complete access: request, RAM wait cycles, response, return to idle
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        logic is_d;
        logic wr;
        int   acc;
        bit   done;
        is_d = (v.kind != 0);
        wr   = (v.kind >= 2);
        if (!is_d) m_iload = v.load;
        else if (!wr) m_dload = v.load;
        e.is_d = is_d;
        e.data = is_d ? m_dload : m_iload;
        sb.push_back(e);
        iREN   = !is_d;
        dREN   = (v.kind == 1) || (v.kind == 3);
        dWEN   = wr;
        iaddr  = v.addr;
        daddr  = v.addr;
        dstore = v.store;
        tick();
        // scramble request fields after grant; the latched copy must hold
        iaddr  = v.addr ^ 32'h300;
        daddr  = v.addr ^ 32'h300;
        dstore = ~v.store;
        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            chk($sformatf("v%0d ram_ren", idx), 32'(ram_ren), 32'(!wr));
            chk($sformatf("v%0d ram_wen", idx), 32'(ram_wen), 32'(wr));
            chk($sformatf("v%0d ram_addr", idx), ram_addr, v.addr);
            if (wr) chk($sformatf("v%0d ram_store", idx), ram_store, v.store);
            chk($sformatf("v%0d early_hit", idx), 32'({ihit, dhit}), 32'd0);
            acc++;
            ram_load = v.load;
            ram_rdy  = (acc == v.waits + 1);
            done     = ram_rdy;
            tick();
        end
        if (!done) chk($sformatf("v%0d access_timeout", idx), 32'd1, 32'd0);
        ram_rdy  = 1'b0;
        ram_load = $urandom;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d sb_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d ihit", idx), 32'(ihit), 32'(!e.is_d));
            chk($sformatf("v%0d dhit", idx), 32'(dhit), 32'(e.is_d));
            chk($sformatf("v%0d resp_data", idx), e.is_d ? dload : iload, e.data);
        end
        chk($sformatf("v%0d iload_model", idx), iload, m_iload);
        chk($sformatf("v%0d dload_model", idx), dload, m_dload);
        chk($sformatf("v%0d resp_enables", idx), 32'({ram_ren, ram_wen}), 32'd0);
        tick();
        chk($sformatf("v%0d idle_hits", idx), 32'({ihit, dhit}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0};
        vecs[1] = '{2, 32'h0000_0100, 32'h0000_1234, 32'h0BAD_0BAD, 3};
        vecs[2] = '{1, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1};
        vecs[3] = '{3, 32'h0000_0008, 32'h0000_0055, 32'h7777_7777, 0};
        vecs[4] = '{0, 32'h0000_0044, 32'h0,         32'h1357_9BDF, 2};
        vecs[5] = '{1, 32'h0000_0200, 32'h0,         32'hA5A5_5A5A, 0};

        // reset with arbitrary inputs active
        RST = 1'b1;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; ram_rdy = 1'b1;
        iaddr = 32'h1111_2222; daddr = 32'h3333_4444; dstore = 32'h5555_6666;
        ram_load = 32'h7777_8888;
        tick();
        tick();
        chk("rst ihit", 32'(ihit), 32'd0);
        chk("rst dhit", 32'(dhit), 32'd0);
        chk("rst iload", iload, 32'd0);
        chk("rst dload", dload, 32'd0);
        chk("rst ram_ren", 32'(ram_ren), 32'd0);
        chk("rst ram_wen", 32'(ram_wen), 32'd0);
        chk("rst ram_addr", ram_addr, 32'd0);
        chk("rst ram_store", ram_store, 32'd0);
        quiet_inputs();
        RST = 1'b0;
        tick();
        chk("post_rst idle", 32'({ram_ren, ram_wen, ihit, dhit}), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // reset during a data read that never sees ram_rdy
        dREN = 1'b1; daddr = 32'h0000_0044;
        tick();
        chk("abort ram_ren_before", 32'(ram_ren), 32'd1);
        chk("abort ram_addr_before", ram_addr, 32'h0000_0044);
        RST = 1'b1;
        dREN = 1'b0;
        tick();
        m_iload = '0;
        m_dload = '0;
        chk("abort ram_ren", 32'(ram_ren), 32'd0);
        chk("abort dhit", 32'(dhit), 32'd0);
        chk("abort ram_addr", ram_addr, 32'd0);
        chk("abort dload", dload, 32'd0);
        RST = 1'b0;
        ram_rdy = 1'b1;
        tick();
        chk("abort no_hit1", 32'({ihit, dhit}), 32'd0);
        tick();
        chk("abort no_hit2", 32'({ihit, dhit, ram_ren, ram_wen}), 32'd0);
        ram_rdy = 1'b0;

        // fairness: both requesters held continuously, RAM always ready
        begin
            exp_t e;
            int   g;
            g = 0;
            for (int k = 0; k < 10; k++) begin
                e.is_d = ((k % 5) != 4);
                e.data = '0;
                sb.push_back(e);
            end
            iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ram_rdy = 1'b1;
            iaddr = 32'h0000_1000; daddr = 32'h0000_2000; ram_load = 32'h0000_00AA;
            for (int c = 0; c < 60 && g < 10; c++) begin
                tick();
                if (ihit || dhit) begin
                    e = sb.pop_front();
                    chk($sformatf("grant%0d is_data", g), 32'(dhit), 32'(e.is_d));
                    chk($sformatf("grant%0d single_hit", g), 32'(ihit & dhit), 32'd0);
                    g++;
                end
            end
            if (g < 10) chk("fairness timeout", 32'(g), 32'd10);
            quiet_inputs();
            tick();
            tick();
            chk("fairness idle", 32'({ram_ren, ram_wen, ihit, dhit}), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
